mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters SHALL be none; all encodings SHALL come from the shared package.
REQ-002 clk  in  1  single clock; every state and flag update SHALL occur on the rising edge.
REQ-003 reset  in  1  reset SHALL be synchronous and active-low.
REQ-004 Instr  in  32  latched instruction; fields used: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
REQ-005 ALUFlags  in  4  {N,Z,C,V} of the current-cycle ALU result.
REQ-006 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath strobes and selects.
REQ-007 RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects.
REQ-008 ALUControl  out  4  ALU operation.
REQ-009 Illegal  out  1  sticky unsupported-opcode indicator.

Function
REQ-010 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH and ILLEGAL, held in one state register.
REQ-011 Outputs SHALL be combinational from the state register, Instr and the flags register (Moore style), with no output registers.
REQ-012 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=01 (PC), ALUSrcB=10 (4), ALU ADD, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ALU ADD, ResultSrc=10 and write enables 0. op=00 goes to EXECI if funct[5]=1, else EXECR. op=01 goes to MEMADR. op=10 goes to BRANCH. op=11 goes to ILLEGAL.
REQ-014 EXECR SHALL use ALUSrcA=00 and ALUSrcB=00; EXECI SHALL use ALUSrcA=00, ALUSrcB=01 and ImmSrc=00. Both go to ALUWB.
REQ-015 Data-processing decode on funct[4:1] SHALL be: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP. CMP SHALL force S=1 and suppress the writeback. Any other code SHALL behave as ILLEGAL.
REQ-016 ALUWB SHALL drive ResultSrc=00 and RegWrite=CondEx&~CMP, then go to FETCH.
REQ-017 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ImmSrc=01, ALU ADD if U (funct[3]) is 1 else SUB. L (funct[0])=1 goes to MEMRD, otherwise MEMWR.
REQ-018 MEMRD SHALL drive AdrSrc=1 and ResultSrc=00, then go to MEMWB.
REQ-019 MEMWB SHALL drive ResultSrc=01 and RegWrite=CondEx, then go to FETCH.
REQ-020 MEMWR SHALL drive AdrSrc=1, ResultSrc=00, RegSrc[1]=1 and MemWrite=CondEx, then go to FETCH.
REQ-021 BRANCH SHALL drive RegSrc[0]=1, ALUSrcA=10, ALUSrcB=01, ImmSrc=10, ALU ADD, ResultSrc=10 and PCWrite=CondEx, then go to FETCH.
REQ-022 Any RegWrite with Rd=15 SHALL also assert PCWrite with the same condition gating.
REQ-023 CondEx SHALL implement all ARM cond codes 0000-1110 against the registered NZCV; 1111 SHALL evaluate false.
REQ-024 The flags register SHALL load from ALUFlags at the end of EXECR/EXECI when S=1 and CondEx=1.
- N and Z SHALL always load.
- C and V SHALL load only for ADD, SUB and CMP; AND and ORR SHALL preserve them.
REQ-025 Cycle counts SHALL be: branch 3, data-processing 4, STR 4, LDR 5. A failed condition SHALL NOT shorten the sequence.

Reset
REQ-026 With reset=0 at a clock edge, state SHALL become FETCH, flags SHALL become 0000 and Illegal SHALL become 0.
REQ-027 While reset=0, PCWrite, MemWrite, RegWrite and IRWrite SHALL be forced to 0. Reset mid-instruction SHALL abandon it with no further writes.

Configuration
REQ-028 Macro MC_CTRL_ILLEGAL_TRAP_EN defined: ILLEGAL SHALL set Illegal=1, hold all write enables at 0 and remain in ILLEGAL until reset.
REQ-029 Macro MC_CTRL_ILLEGAL_TRAP_EN undefined: ILLEGAL SHALL act as a one-cycle NOP returning to FETCH, and Illegal SHALL be tied to 0.

Structure
REQ-030 Package mc_ctrl_pkg SHALL hold the state enum, ALUControl encodings (ADD=0000, SUB=0001, AND=0010, ORR=0011), mux-select constants and cond-code constants.
REQ-031 Combinational sub-module cond_unit SHALL compute CondEx from cond and the flags register; the flags register itself SHALL stay in mc_controller.

Verification
REQ-032 Hold reset=0 for 2 cycles, then release -> first cycle shows IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
REQ-033 0xE0821003 (ADD R1,R2,R3) -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4, ALUControl=0000 in EXECR.
REQ-034 0xE3500000 (CMP R0,#0) with ALUFlags=0100 -> Z=1 and RegWrite=0 throughout.
- Then 0x0A000002 (BEQ) -> PCWrite=1 in BRANCH.
- 0x1A000002 (BNE) -> PCWrite=0 in BRANCH.
REQ-035 0xE5921004 (LDR) -> 5 cycles, AdrSrc=1 in MEMRD, RegWrite=1 with ResultSrc=01 in MEMWB.
- 0xE5821004 (STR) -> MemWrite=1 and RegSrc[1]=1 in cycle 4.
REQ-036 0xEC000000 -> with macro defined, Illegal=1 and IRWrite stays 0 until reset; without macro, FETCH recurs on cycle 4.
REQ-037 reset=0 asserted during MEMRD of an LDR -> no RegWrite, state FETCH on the following cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU ops, mux selects, cond codes.
// Pure definitions with no timing and no flow control.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_ILLEGAL
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;

    localparam logic [1:0] SRCA_REG = 2'b00, SRCA_PC = 2'b01, SRCA_BR = 2'b10;
    localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
    localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
    localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    typedef struct packed {
        logic       vld;
        logic [3:0] alu;
        logic       cmp;
        logic       cv_upd;
    } dp_dec_t;

    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d = '{vld: 1'b1, alu: ALU_ADD, cmp: 1'b0, cv_upd: 1'b1};
        case (cmd)
            CMD_ADD: d.alu = ALU_ADD;
            CMD_SUB: d.alu = ALU_SUB;
            CMD_AND: begin d.alu = ALU_AND; d.cv_upd = 1'b0; end
            CMD_ORR: begin d.alu = ALU_ORR; d.cv_upd = 1'b0; end
            CMD_CMP: begin d.alu = ALU_SUB; d.cmp = 1'b1; end
            default: d.vld = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_controller_cond.sv
// Condition evaluator: ARM cond field against registered {N,Z,C,V}; purely combinational.
// Zero latency, no flow control.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control FSM with Moore outputs from state/Instr/flags; no output registers, no backpressure.
// MC_CTRL_ILLEGAL_TRAP_EN: ILLEGAL traps until reset and raises Illegal; otherwise a one-cycle NOP.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        Illegal
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       pcw, mw, rw, irw;

    logic [1:0] op;
    logic [5:0] funct;
    dp_dec_t    dp;
    logic       s_eff, rd15;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign dp           = dp_decode(funct[4:1]);
    assign s_eff        = funct[0] | dp.cmp;
    assign rd15         = (Instr[15:12] == 4'hF);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    cond_unit u_cond (
        .cond    (Instr[31:28]),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        pcw        = 1'b0;
        mw         = 1'b0;
        rw         = 1'b0;
        irw        = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_DP;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                irw       = 1'b1;
                pcw       = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (op)
                    OP_DP:   state_d = !dp.vld ? S_ILLEGAL : (funct[5] ? S_EXECI : S_EXECR);
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                ALUControl = dp.alu;
                // Logic ops leave C/V alone so a preceding compare's carry survives.
                if (s_eff && cond_ex)
                    flags_d = {ALUFlags[3:2], dp.cv_upd ? ALUFlags[1:0] : flags_q[1:0]};
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                rw      = cond_ex & ~dp.cmp;
                pcw     = rw & rd15;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_MEM;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
                state_d    = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw        = cond_ex;
                pcw       = rw & rd15;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                RegSrc  = 2'b10;
                mw      = cond_ex;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                RegSrc    = 2'b01;
                ALUSrcA   = SRCA_BR;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALU;
                pcw       = cond_ex;
                state_d   = S_FETCH;
            end
            S_ILLEGAL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                state_d = S_ILLEGAL;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Write strobes are squashed for the whole reset-low cycle, even mid-instruction.
    assign PCWrite  = reset & pcw;
    assign MemWrite = reset & mw;
    assign RegWrite = reset & rw;
    assign IRWrite  = reset & irw;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign Illegal = (state_q == S_ILLEGAL);
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against a per-instruction cycle model plus directed literal checks.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Illegal;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [3:0]  ALUControl;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    typedef struct packed {
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] regsrc, srca, srcb, res, imm;
        logic [3:0] alu;
        logic       ill;
    } out_t;

    out_t        act, exp_o, exp_m;
    out_t        seen [8];
    logic        exp_vld = 1'b0;
    int          step = 0;
    int          n_chk = 0, n_pass = 0;
    logic [3:0]  mflags = 4'b0000;
    logic [31:0] ins;

    assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, ALUControl, Illegal};

    // ARM condition semantics: pairs of codes share a test, odd code inverts it.
    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'b0000;
            4'b0010: return 4'b0001;
            4'b0000: return 4'b0010;
            4'b1100: return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    // 0 data-processing, 1 memory, 2 branch, 3 illegal
    function automatic int cls(input logic [31:0] i);
        logic [3:0] cmd;
        cmd = i[24:21];
        case (i[27:26])
            2'b00:   return (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}) ? 0 : 3;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int model_len(input logic [31:0] i);
        case (cls(i))
            0:       return 4;
            1:       return i[20] ? 5 : 4;
            default: return 3;
        endcase
    endfunction

    function automatic void model_step(input logic [31:0] i, input int k, input logic [3:0] fl,
                                       output out_t e, output out_t m);
        int         c;
        logic       ce, rd15;
        logic [3:0] cmd;
        c    = cls(i);
        ce   = m_cond(i[31:28], fl);
        cmd  = i[24:21];
        rd15 = (i[15:12] == 4'hF);
        e = '0;
        m = '0;
        m.pcw = 1'b1; m.mw = 1'b1; m.rw = 1'b1; m.irw = 1'b1; m.ill = 1'b1;
        if (k <= 1) begin
            e.srca = 2'b01; e.srcb = 2'b10; e.alu = 4'b0000; e.res = 2'b10;
            m.srca = '1; m.srcb = '1; m.alu = '1; m.res = '1;
            if (k == 0) begin e.irw = 1'b1; e.pcw = 1'b1; m.adr = 1'b1; end
        end else if (c == 0) begin
            if (k == 2) begin
                e.srca = 2'b00; e.srcb = i[25] ? 2'b01 : 2'b00; e.alu = alu_of(cmd);
                m.srca = '1; m.srcb = '1; m.alu = '1;
                if (i[25]) m.imm = '1;
            end else begin
                m.res = '1;
                e.rw  = ce && (cmd != 4'b1010);
                e.pcw = e.rw && rd15;
            end
        end else if (c == 1) begin
            if (k == 2) begin
                e.srca = 2'b00; e.srcb = 2'b01; e.imm = 2'b01; e.alu = i[23] ? 4'b0000 : 4'b0001;
                m.srca = '1; m.srcb = '1; m.imm = '1; m.alu = '1;
            end else if (k == 3) begin
                e.adr = 1'b1; m.adr = 1'b1; m.res = '1;
                if (!i[20]) begin e.regsrc[1] = 1'b1; m.regsrc[1] = 1'b1; e.mw = ce; end
            end else begin
                e.res = 2'b01; m.res = '1; e.rw = ce; e.pcw = ce && rd15;
            end
        end else if (c == 2) begin
            e.regsrc[0] = 1'b1; m.regsrc[0] = 1'b1;
            e.srca = 2'b10; e.srcb = 2'b01; e.imm = 2'b10; e.alu = 4'b0000; e.res = 2'b10;
            m.srca = '1; m.srcb = '1; m.imm = '1; m.alu = '1; m.res = '1;
            e.pcw = ce;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            e.ill = 1'b1;
`endif
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0]  cmds [5];
        int          c;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        r = $urandom;
        c = $urandom_range(0, 2);
        r[27:26] = 2'(c);
        if (c == 0) begin
            r[24:21] = cmds[$urandom_range(0, 4)];
            if (r[20] || r[24:21] == 4'b1010) r[31:28] = 4'hE;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (exp_vld) begin
            n_chk++;
            if (((act ^ exp_o) & exp_m) == '0) n_pass++;
            else $display("FAIL cycle ins=%08h step=%0d act=%05h exp=%05h mask=%05h",
                          Instr, step, act, exp_o, exp_m);
            seen[step] = act;
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    endtask

    task automatic run_instr(input logic [31:0] i, input int n, input bit frc, input logic [3:0] fv);
        logic       ce;
        logic [3:0] af, cmd;
        cmd = i[24:21];
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            reset    = 1'b1;
            Instr    = i;
            af       = frc ? fv : 4'($urandom);
            ALUFlags = af;
            model_step(i, k, mflags, exp_o, exp_m);
            ce      = m_cond(i[31:28], mflags);
            step    = k;
            exp_vld = 1'b1;
            @(negedge clk);
            if (k == 2 && cls(i) == 0 && ce && (i[20] || cmd == 4'b1010)) begin
                mflags[3:2] = af[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mflags[1:0] = af[1:0];
            end
        end
        #1;
    endtask

    // One reset-low cycle per iteration; with chk_adr the abandoned MEMRD select is still visible.
    task automatic do_reset(input int n, input bit chk_adr);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            reset    = 1'b0;
            ALUFlags = 4'($urandom);
            exp_o = '0;
            exp_m = '0;
            exp_m.pcw = 1'b1; exp_m.mw = 1'b1; exp_m.rw = 1'b1; exp_m.irw = 1'b1;
            if (chk_adr) begin exp_o.adr = 1'b1; exp_m.adr = 1'b1; end
            step    = 7;
            exp_vld = 1'b1;
            @(negedge clk);
        end
        #1;
        mflags = 4'b0000;
    endtask

    initial begin
        reset    = 1'b0;
        Instr    = 32'h0;
        ALUFlags = 4'h0;
        do_reset(2, 1'b0);

        ins = 32'hE0821003;
        run_instr(ins, model_len(ins), 1'b0, 4'h0);
        chk("rst_fetch_irw",  32'(seen[0].irw),  1);
        chk("rst_fetch_pcw",  32'(seen[0].pcw),  1);
        chk("rst_fetch_adr",  32'(seen[0].adr),  0);
        chk("rst_fetch_srca", 32'(seen[0].srca), 1);
        chk("rst_fetch_srcb", 32'(seen[0].srcb), 2);
        chk("rst_fetch_res",  32'(seen[0].res),  2);
        chk("add_len", model_len(ins), 4);
        chk("add_alu", 32'(seen[2].alu), 0);
        chk("add_rw",  32'({seen[0].rw, seen[1].rw, seen[2].rw, seen[3].rw}), 32'b0001);

        ins = 32'hE3500000;
        run_instr(ins, model_len(ins), 1'b1, 4'b0100);
        chk("cmp_rw", 32'({seen[0].rw, seen[1].rw, seen[2].rw, seen[3].rw}), 0);
        chk("cmp_flags_model", 32'(mflags), 32'b0100);

        ins = 32'h0A000002;
        run_instr(ins, model_len(ins), 1'b0, 4'h0);
        chk("beq_len", model_len(ins), 3);
        chk("beq_pcw", 32'(seen[2].pcw), 1);
        ins = 32'h1A000002;
        run_instr(ins, model_len(ins), 1'b0, 4'h0);
        chk("bne_pcw", 32'(seen[2].pcw), 0);

        ins = 32'hE5921004;
        run_instr(ins, model_len(ins), 1'b0, 4'h0);
        chk("ldr_len", model_len(ins), 5);
        chk("ldr_adr", 32'(seen[3].adr), 1);
        chk("ldr_wb",  32'({seen[4].rw, seen[4].res}), 32'b101);
        ins = 32'hE5821004;
        run_instr(ins, model_len(ins), 1'b0, 4'h0);
        chk("str_len", model_len(ins), 4);
        chk("str_mw",  32'({seen[3].mw, seen[3].regsrc[1]}), 32'b11);

        for (int n = 0; n < 300; n++) begin
            ins = rand_instr();
            run_instr(ins, model_len(ins), 1'b0, 4'h0);
        end

        run_instr(32'hE5921004, 3, 1'b0, 4'h0);
        do_reset(1, 1'b1);
        chk("abort_rw", 32'(seen[7].rw), 0);
        run_instr(32'hE0821003, 4, 1'b0, 4'h0);
        chk("abort_fetch", 32'(seen[0].irw), 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        run_instr(32'hEC000000, 6, 1'b0, 4'h0);
        chk("trap_ill", 32'(seen[5].ill), 1);
        chk("trap_irw", 32'(seen[5].irw), 0);
        do_reset(1, 1'b0);
        run_instr(32'hE1A00000, 5, 1'b0, 4'h0);
        chk("trap_badcmd", 32'(seen[4].ill), 1);
        do_reset(1, 1'b0);
`else
        chk("ill_len", model_len(32'hEC000000), 3);
        run_instr(32'hE1A00000, 3, 1'b0, 4'h0);
        run_instr(32'hEC000000, 3, 1'b0, 4'h0);
        chk("nop_ill", 32'(seen[2].ill), 0);
`endif
        run_instr(32'hE0821003, 4, 1'b0, 4'h0);
        chk("ill_fetch_recur", 32'(seen[0].irw), 1);

        exp_vld = 1'b0;
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
